// File: rtl/rv_alu_md_pkg.sv
// Shared types for the rv_alu_md execute-stage ALU: opcodes, FSM states and
// small decode helpers.
package rv_alu_md_pkg;

  localparam int unsigned OpW = 5;
  localparam int unsigned StW = 2;

  typedef enum logic [OpW-1:0] {
    OpAdd    = 5'd0,
    OpSub    = 5'd1,
    OpSll    = 5'd2,
    OpSlt    = 5'd3,
    OpSltu   = 5'd4,
    OpXor    = 5'd5,
    OpSrl    = 5'd6,
    OpSra    = 5'd7,
    OpOr     = 5'd8,
    OpAnd    = 5'd9,
    OpMul    = 5'd16,
    OpMulh   = 5'd17,
    OpMulhsu = 5'd18,
    OpMulhu  = 5'd19,
    OpDiv    = 5'd20,
    OpDivu   = 5'd21,
    OpRem    = 5'd22,
    OpRemu   = 5'd23
  } alu_op_e;

  typedef enum logic [StW-1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StResp = 2'd2
  } state_e;

  // True for the four divide/remainder opcodes.
  function automatic logic is_div_op(alu_op_e op);
    return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/rv_alu_md_iter.sv
// Iterative M-extension engine: shift-add multiplier and restoring divider
// sharing one register set. Works on operand magnitudes for XLEN cycles and
// applies the result sign combinationally in the last cycle, when done is high.
// Only instantiated when RV_ALU_MD_M_EN is defined.
module rv_alu_md_iter
  import rv_alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  logic            active_q;
  logic [CntW-1:0] cnt_q;
  alu_op_e         op_q;
  logic            neg_q;
  // acc: product high half / partial remainder; lo: multiplier / quotient;
  // mag: multiplicand / divisor magnitude.
  logic [XLEN-1:0] acc_q, lo_q, mag_q;

  logic            sign_a, sign_b, neg_start;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_op;
  logic [XLEN:0]   add_sum, shifted, sub_diff;
  logic [XLEN-1:0] acc_n, lo_n, quo, rem;
  logic [2*XLEN-1:0] prod;

  // Operand magnitudes and the sign of the final result, captured at start
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op)
      OpMul, OpMulh, OpDiv, OpRem: begin
        sign_a = a[XLEN-1];
        sign_b = b[XLEN-1];
      end
      OpMulhsu: sign_a = a[XLEN-1];
      default: ;
    endcase
    mag_a     = sign_a ? -a : a;
    mag_b     = sign_b ? -b : b;
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_start = (op == OpRem) ? sign_a : (sign_a ^ sign_b);
  end

  // One multiply or divide step, plus sign fix-up of the final step's values
  always_comb begin
    div_op   = is_div_op(op_q);
    add_sum  = {1'b0, acc_q} + ({(XLEN+1){lo_q[0]}} & {1'b0, mag_q});
    shifted  = {acc_q, lo_q[XLEN-1]};
    sub_diff = shifted - {1'b0, mag_q};
    if (div_op) begin
      if (!sub_diff[XLEN]) begin
        acc_n = sub_diff[XLEN-1:0];
        lo_n  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted[XLEN-1:0];
        lo_n  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_n = add_sum[XLEN:1];
      lo_n  = {add_sum[0], lo_q[XLEN-1:1]};
    end
    prod = neg_q ? -{acc_n, lo_n} : {acc_n, lo_n};
    quo  = neg_q ? -lo_n : lo_n;
    rem  = neg_q ? -acc_n : acc_n;
    case (op_q)
      OpMul:                    result = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: result = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:            result = quo;
      default:                  result = rem;
    endcase
  end

  assign done = active_q && (cnt_q == LastCnt);

  // Engine registers: load on start, step while active, clear on kill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OpAdd;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      mag_q    <= '0;
    end else if (kill) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      op_q     <= op;
      neg_q    <= neg_start;
      acc_q    <= '0;
      if (is_div_op(op)) begin
        lo_q  <= mag_a;
        mag_q <= mag_b;
      end else begin
        lo_q  <= mag_b;
        mag_q <= mag_a;
      end
    end else if (active_q) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rv_alu_md.sv
// Sequential RV32I/RV64I ALU with valid/ready request and response, registered
// results and flags. With RV_ALU_MD_M_EN defined, M-extension ops run on an
// iterative engine (XLEN cycles) except for the divide fast paths; without it
// opcodes 16-23 respond as illegal and busy is tied low.
module rv_alu_md
  import rv_alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OpW-1:0]  req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_negative,
  output logic            rsp_overflow,
  output logic            rsp_illegal,
  output logic            busy
);

  localparam int unsigned ShW = $clog2(XLEN);
`ifdef RV_ALU_MD_M_EN
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};
`endif

  state_e          state_q, state_d;
  alu_op_e         op;
  logic            accept;
  logic [XLEN-1:0] fast_res, sum, diff;
  logic [ShW-1:0]  shamt;
  logic            fast_ovf, fast_ill, to_iter;
  logic [XLEN-1:0] res_q;
  logic            zero_q, neg_q, ovf_q, ill_q;

  assign op        = alu_op_e'(req_op);
  assign req_ready = !flush && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
  assign accept    = req_valid && req_ready;

  // Single-cycle result for base ops and M-op fast paths; flags iterative ops
  always_comb begin
    sum      = req_a + req_b;
    diff     = req_a - req_b;
    shamt    = req_b[ShW-1:0];
    fast_res = '0;
    fast_ovf = 1'b0;
    fast_ill = 1'b0;
    to_iter  = 1'b0;
    case (op)
      OpAdd: begin
        fast_res = sum;
        fast_ovf = (req_a[XLEN-1] == req_b[XLEN-1]) && (sum[XLEN-1] != req_a[XLEN-1]);
      end
      OpSub: begin
        fast_res = diff;
        fast_ovf = (req_a[XLEN-1] != req_b[XLEN-1]) && (diff[XLEN-1] != req_a[XLEN-1]);
      end
      OpSll:  fast_res = req_a << shamt;
      OpSlt:  fast_res = {{(XLEN-1){1'b0}}, $signed(req_a) < $signed(req_b)};
      OpSltu: fast_res = {{(XLEN-1){1'b0}}, req_a < req_b};
      OpXor:  fast_res = req_a ^ req_b;
      OpSrl:  fast_res = req_a >> shamt;
      OpSra:  fast_res = $unsigned($signed(req_a) >>> shamt);
      OpOr:   fast_res = req_a | req_b;
      OpAnd:  fast_res = req_a & req_b;
`ifdef RV_ALU_MD_M_EN
      OpMul, OpMulh, OpMulhsu, OpMulhu: to_iter = 1'b1;
      OpDiv, OpRem: begin
        if (req_b == '0) begin
          fast_res = (op == OpDiv) ? '1 : req_a;
        end else if ((req_a == MinVal) && (req_b == '1)) begin
          fast_res = (op == OpDiv) ? MinVal : '0;
          fast_ovf = (op == OpDiv);
        end else begin
          to_iter = 1'b1;
        end
      end
      OpDivu, OpRemu: begin
        if (req_b == '0) fast_res = (op == OpDivu) ? '1 : req_a;
        else             to_iter  = 1'b1;
      end
`endif
      default: fast_ill = 1'b1;
    endcase
  end

`ifdef RV_ALU_MD_M_EN
  logic            iter_done;
  logic [XLEN-1:0] iter_res;

  rv_alu_md_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (flush),
    .start  (accept && to_iter),
    .op     (op),
    .a      (req_a),
    .b      (req_b),
    .done   (iter_done),
    .result (iter_res)
  );

  assign busy = (state_q == StIter);
`else
  assign busy = 1'b0;
`endif

  // Next state: accept from IDLE or on a RESP handshake, flush wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept)                                state_d = to_iter ? StIter : StResp;
        else if ((state_q == StResp) && rsp_ready) state_d = StIdle;
      end
      StIter: begin
`ifdef RV_ALU_MD_M_EN
        if (iter_done) state_d = StResp;
`endif
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Response registers: loaded from the fast path or from the engine's last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else if (accept && !to_iter) begin
      res_q  <= fast_res;
      zero_q <= (fast_res == '0);
      neg_q  <= fast_res[XLEN-1];
      ovf_q  <= fast_ovf;
      ill_q  <= fast_ill;
`ifdef RV_ALU_MD_M_EN
    end else if ((state_q == StIter) && iter_done) begin
      res_q  <= iter_res;
      zero_q <= (iter_res == '0);
      neg_q  <= iter_res[XLEN-1];
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
`endif
    end
  end

  assign rsp_valid    = (state_q == StResp);
  assign rsp_result   = res_q;
  assign rsp_zero     = zero_q;
  assign rsp_negative = neg_q;
  assign rsp_overflow = ovf_q;
  assign rsp_illegal  = ill_q;

endmodule

// File: tb/tb_rv_alu_md.sv
// Self-checking bench for rv_alu_md (XLEN=32): arithmetic reference model with
// an expected-response queue checked every cycle, plus directed literal cases.
module tb_rv_alu_md;

`ifdef RV_ALU_MD_M_EN
  localparam bit MEn = 1'b1;
`else
  localparam bit MEn = 1'b0;
`endif
  localparam int MLat  = MEn ? 33 : 1;
  localparam int MBusy = MEn ? 32 : 0;
  localparam longint IMax = 64'sd2147483647;
  localparam longint IMin = -IMax - 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;   // {zero, negative, overflow, illegal}
    int          lat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b, rsp_result;
  logic        rsp_zero, rsp_negative, rsp_overflow, rsp_illegal, busy;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  bit   head_seen = 1'b0;

  rv_alu_md #(
    .XLEN (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .rsp_overflow (rsp_overflow),
    .rsp_illegal  (rsp_illegal),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the ISA arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, wide;
    logic [63:0] p;
    logic        ovf, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = 32'd0; e.lat = 1; e.due = 0;
    ovf = 1'b0; ill = 1'b0; p = 64'd0; wide = 0;
    case (op)
      5'd0: begin wide = sa + sb; e.res = a + b; ovf = (wide > IMax) || (wide < IMin); end
      5'd1: begin wide = sa - sb; e.res = a - b; ovf = (wide > IMax) || (wide < IMin); end
      5'd2: e.res = a << b[4:0];
      5'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
      5'd4: e.res = (a < b) ? 32'd1 : 32'd0;
      5'd5: e.res = a ^ b;
      5'd6: e.res = a >> b[4:0];
      5'd7: e.res = $unsigned($signed(a) >>> b[4:0]);
      5'd8: e.res = a | b;
      5'd9: e.res = a & b;
`ifdef RV_ALU_MD_M_EN
      5'd16: begin p = sa * sb; e.res = p[31:0]; e.lat = 33; end
      5'd17: begin p = sa * sb; e.res = p[63:32]; e.lat = 33; end
      5'd18: begin p = sa * longint'({32'd0, b}); e.res = p[63:32]; e.lat = 33; end
      5'd19: begin p = {32'd0, a} * {32'd0, b}; e.res = p[63:32]; e.lat = 33; end
      5'd20, 5'd22: begin
        if (b == 32'd0) e.res = (op == 5'd20) ? 32'hFFFF_FFFF : a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.res = (op == 5'd20) ? 32'h8000_0000 : 32'd0;
          ovf   = (op == 5'd20);
        end else begin
          wide  = (op == 5'd20) ? sa / sb : sa % sb;
          e.res = wide[31:0];
          e.lat = 33;
        end
      end
      5'd21, 5'd23: begin
        if (b == 32'd0) e.res = (op == 5'd21) ? 32'hFFFF_FFFF : a;
        else begin
          e.res = (op == 5'd21) ? a / b : a % b;
          e.lat = 33;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
    e.fl = {e.res == 32'd0, e.res[31], ovf, ill};
    return e;
  endfunction

  // Every cycle with a response: compare against the queue head.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          chk("rsp_value", {28'd0, rsp_result, rsp_zero, rsp_negative, rsp_overflow, rsp_illegal},
              {28'd0, exp_q[0].res, exp_q[0].fl});
          if (!head_seen) chk("rsp_latency", 64'(cyc), 64'(exp_q[0].due));
          head_seen = 1'b1;
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end else if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
        chk("rsp_missing", 64'(rsp_valid), 64'd1);
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int acc);
    exp_t e;
    int   n;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    acc = -1;
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(req_ready), 64'd1);
    end else begin
      e = model(op, a, b);
      e.due = cyc + e.lat;
      exp_q.push_back(e);
      acc = cyc;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 5'($urandom); req_a = $urandom; req_b = $urandom;
  endtask

  task automatic wait_rsp(output int vcyc, output logic [31:0] res, output logic [3:0] fl,
                          output int nbusy);
    vcyc = -1; nbusy = 0; res = 32'd0; fl = 4'd0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        vcyc = cyc;
        res  = rsp_result;
        fl   = {rsp_zero, rsp_negative, rsp_overflow, rsp_illegal};
        break;
      end
      if (busy) nbusy++;
    end
    if (vcyc < 0) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eres, input logic [3:0] efl,
                       input int elat, input int ebusy);
    int acc, vcyc, nb;
    logic [31:0] res;
    logic [3:0]  fl;
    send(op, a, b, acc);
    wait_rsp(vcyc, res, fl, nb);
    chk({name, "_res"}, 64'(res), 64'(eres));
    chk({name, "_flags"}, 64'(fl), 64'(efl));
    chk({name, "_lat"}, 64'(vcyc - acc), 64'(elat));
    chk({name, "_busy"}, 64'(nb), 64'(ebusy));
  endtask

  initial begin
    int acc, t0, vcyc, nb;
    logic [31:0] res;
    logic [3:0]  fl;
    exp_t e;

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 5'd0; req_a = 32'd0; req_b = 32'd0;
    #2;
    chk("reset_outputs", {57'd0, rsp_valid, rsp_zero, rsp_negative, rsp_overflow, rsp_illegal,
        busy, |rsp_result}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Scenario 1 and a pass over every base op, back to back.
    do_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110, 1, 0);
    t0 = cyc;
    send(5'd1, 32'h8000_0000, 32'h1, acc);
    send(5'd2, 32'h1, 32'h3F, acc);
    send(5'd3, 32'hFFFF_FFFF, 32'h1, acc);
    send(5'd4, 32'hFFFF_FFFF, 32'h1, acc);
    send(5'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, acc);
    send(5'd6, 32'h8000_0000, 32'h4, acc);
    send(5'd7, 32'h8000_0000, 32'h24, acc);
    send(5'd8, 32'h1200_0034, 32'h0056_7800, acc);
    send(5'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, acc);
    send(5'd1, 32'h5, 32'h5, acc);
    chk("b2b_cycles", 64'(cyc - t0), 64'd10);

    // Scenario 2: iterative multiplies.
    do_op("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MEn ? 32'hFFFF_FFFE : 32'd0,
          MEn ? 4'b0100 : 4'b1001, MLat, MBusy);
    do_op("mulh", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MEn ? 4'b1000 : 4'b1001, MLat, MBusy);

    // Scenario 3: divide fast paths.
    do_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, MEn ? 32'h8000_0000 : 32'd0,
          MEn ? 4'b0110 : 4'b1001, 1, 0);
    do_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, MEn ? 4'b1000 : 4'b1001, 1, 0);
    do_op("divu_z", 5'd21, 32'd7, 32'd0, MEn ? 32'hFFFF_FFFF : 32'd0,
          MEn ? 4'b0100 : 4'b1001, 1, 0);
    do_op("remu_z", 5'd23, 32'd7, 32'd0, MEn ? 32'd7 : 32'd0, MEn ? 4'b0000 : 4'b1001, 1, 0);

    // Scenario 4: signed divide with rounding toward zero.
    do_op("div_neg", 5'd20, 32'hFFFF_FFEC, 32'd3, MEn ? 32'hFFFF_FFFA : 32'd0,
          MEn ? 4'b0100 : 4'b1001, MLat, MBusy);
    do_op("rem_neg", 5'd22, 32'hFFFF_FFEC, 32'd3, MEn ? 32'hFFFF_FFFE : 32'd0,
          MEn ? 4'b0100 : 4'b1001, MLat, MBusy);

    // More M-op patterns, checked by the model only.
    send(5'd16, 32'hFFFF_FFFD, 32'd7, acc);
    send(5'd16, 32'h1234_5678, 32'h9ABC_DEF0, acc);
    send(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
    send(5'd21, 32'd100, 32'd7, acc);
    send(5'd23, 32'd100, 32'd7, acc);
    send(5'd22, 32'd7, 32'hFFFF_FFFD, acc);
    wait_rsp(vcyc, res, fl, nb);

    // Scenario 5: response back-pressure then same-cycle handoff.
    rsp_ready = 1'b0;
    send(5'd0, 32'd5, 32'd6, acc);
    req_valid = 1'b1; req_op = 5'd0; req_a = 32'd100; req_b = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_req_ready", 64'(req_ready), 64'd1);
    e = model(5'd0, 32'd100, 32'hFFFF_FFFF);
    e.due = cyc + 1;
    exp_q.push_back(e);
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(vcyc, res, fl, nb);
    chk("handoff_lat", 64'(vcyc - acc), 64'd1);
    chk("handoff_res", 64'(res), 64'd99);

    // Scenario 6a: flush in cycle 10 of a DIV.
    send(5'd20, 32'd1000, 32'd7, acc);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    exp_q.delete();
    head_seen = 1'b0;
    @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'(MEn));
    chk("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {61'd0, busy, rsp_valid, req_ready}, 64'd1);
    repeat (40) @(negedge clk);

    // Flush alongside a request: request is refused.
    @(posedge clk);
    #1 flush = 1'b1; req_valid = 1'b1; req_op = 5'd0; req_a = 32'd1; req_b = 32'd2;
    @(negedge clk);
    chk("flush_blocks_req", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;

    // Scenario 6b: asynchronous reset in cycle 10 of a MUL.
    send(5'd16, 32'd3, 32'd5, acc);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    exp_q.delete();
    head_seen = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {57'd0, rsp_valid, rsp_zero, rsp_negative, rsp_overflow,
        rsp_illegal, busy, |rsp_result}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;

    // Scenario 6c: undefined opcode.
    do_op("illegal_12", 5'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 4'b1001, 1, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_alu_md.md
# rv_alu_md

Parametrised sequential successor to the single-cycle RV32I ALU. It adds a valid/ready request/response handshake, registered results and an iterative RV M-extension engine: MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU. It sits in the execute stage between issue and writeback, and can stall issue while a multi-cycle operation runs.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous kill of any in-flight operation and any pending response.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_op`  in  5  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- `req_a`, `req_b`  in  XLEN  operands.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_result`  out  XLEN  result.
- `rsp_zero`, `rsp_negative`, `rsp_overflow`, `rsp_illegal`  out  1  flags.
- `busy`  out  1  iterative engine active.

## Operation
- FSM states:
  - IDLE: accept a request. A base op, or an M op taking a fast path, goes to RESP. Any other M op goes to ITER.
  - ITER: XLEN iterations, then RESP.
  - RESP: hold the response. Go to IDLE on handshake; on a handshake with a simultaneous new request, go straight to the new request's target state.
- `req_ready = !flush && (state==IDLE || (state==RESP && rsp_ready))`.
- Operands are latched at acceptance. Later changes on `req_*` have no effect.
- Shifts use `b[$clog2(XLEN)-1:0]`. SLT and SLTU return 0 or 1.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH, MULHSU and MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- The multiplier is shift-add; the divider is restoring. Both operate on magnitudes, with sign fixed up in the final cycle.
- Fast paths, responding like a base op:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return `a`.
  - Signed overflow (`a` = MIN, `b` = −1): DIV returns MIN with `rsp_overflow=1`; REM returns 0.
- Flags:
  - `rsp_zero` = (result==0).
  - `rsp_negative` = result[XLEN-1].
  - `rsp_overflow` = signed overflow for ADD/SUB, the DIV overflow case above, else 0.
  - `rsp_illegal` = undefined opcode; the result is then 0.
- `flush` returns the FSM to IDLE, drops `rsp_valid` and discards the engine state. If `flush` and `req_valid` are high in the same cycle, the request is not accepted.
- Reset values: state IDLE, `rsp_valid=0`, `rsp_result=0`, all flags 0, `busy=0`. `req_ready` is 1 once `rst_n` is high.

## Timing
- Base op or fast path accepted in cycle N: `rsp_valid` high in N+1.
- Iterative op accepted in cycle N: `busy` high in N+1 through N+XLEN; `rsp_valid` high in N+XLEN+1.
- Back-to-back base ops with `rsp_ready` held high sustain one result per cycle.
- The response is held stable while `rsp_valid && !rsp_ready`.
- Reset asserted mid-ITER clears all state immediately (asynchronous), with no response.

## Configuration
- `RV_ALU_MD_M_EN` defined: full M-extension support as above.
- Not defined: the iterative engine and the ITER state are not built. Opcodes 16–23 are treated as undefined: response in N+1, result 0, `rsp_illegal=1`. `busy` is tied to 0.

## Structure
- Package `rv_alu_md_pkg` holds:
  - the opcode enum `alu_op_e`;
  - the FSM state enum;
  - constants for opcode widths.
- One sub-module, `rv_alu_md_iter`: the mul/div engine, with start/done, operands, op and result ports; instantiated only under `RV_ALU_MD_M_EN`.

## Test plan
All scenarios use XLEN=32.
1. ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow=1, negative=1, `rsp_valid` one cycle after accept.
2. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE, and MULH of the same operands → 0x00000000 with zero=1; each `rsp_valid` 33 cycles after accept, `busy` high for 32 cycles.
3. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, overflow=1, in N+1; REM of the same operands → 0; DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
4. DIV −20 / 3 → 0xFFFFFFFA (−6); REM → 0xFFFFFFFE (−2).
5. `rsp_ready` low for 5 cycles → result and flags stable, `req_ready` low; on release, accept the next ADD in the same cycle and see its response in the following cycle.
6. `flush` at cycle 10 of a DIV → no response, IDLE next cycle. `rst_n` low at cycle 10 of a MUL → all outputs at reset values immediately. Opcode 12 → `rsp_illegal=1`, result 0.
